// File: rtl/wb_config_loader.sv
// Wishbone master that turns a header + data word stream into single-beat
// configuration writes, one per data word, to the addressed region slave.
module wb_config_loader #(
   parameter int          NUM_CONFIG_REGIONS = 2,
   parameter logic [31:0] BASE_ADDR          = 32'h3000_0000,
   parameter int          REGION_SHIFT       = 24,
   parameter int          TIMEOUT            = 16,
   parameter int          CNT_W              = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [31:0]                   s_data,
   input  logic                          clr_err,
   output logic                          wbm_cyc_o,
   output logic                          wbm_stb_o,
   output logic                          wbm_we_o,
   output logic [3:0]                    wbm_sel_o,
   output logic [31:0]                   wbm_addr_o,
   output logic [31:0]                   wbm_data_o,
   input  logic [NUM_CONFIG_REGIONS-1:0] wbm_ack_i,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [1:0]                    err_code
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic [2:0]                    state;
   logic [2:0]                    state_n;
   logic [CNT_W-1:0]              remaining;
   logic [7:0]                    tcnt;
   logic [NUM_CONFIG_REGIONS-1:0] region_sel;

   logic             handshake;
   logic [31:0]      hdr_region;
   logic [CNT_W-1:0] hdr_count;
   logic             hdr_bad;
   logic             hdr_empty;
   logic             ack_hit;
   logic             timed_out;
   logic             last_word;

   assign s_ready    = (state == S_IDLE) || (state == S_FETCH);
   assign handshake  = s_valid && s_ready;
   assign hdr_region = {24'b0, s_data[31:24]};
   assign hdr_count  = s_data[CNT_W-1:0];
   assign hdr_bad    = hdr_region >= 32'(NUM_CONFIG_REGIONS);
   assign hdr_empty  = hdr_count == '0;
   assign wbm_sel_o  = 4'hF;

   // Only the latched region's ack bit can retire a write; the ack wins over
   // a timeout that expires in the same cycle.
   assign ack_hit   = |(wbm_ack_i & region_sel);
   assign timed_out = (tcnt == 8'(TIMEOUT - 1)) && !ack_hit;
   assign last_word = remaining == CNT_W'(1);

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (handshake) begin
               if (hdr_bad) begin
                  state_n = S_ERR;
               end else if (!hdr_empty) begin
                  state_n = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (handshake) begin
               state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            if (ack_hit) begin
               state_n = last_word ? S_DONE : S_FETCH;
            end else if (timed_out) begin
               state_n = S_ERR;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         S_ERR: begin
            if (clr_err) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // A zero-count header completes in place, so done has two sources.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_addr_o <= '0;
         wbm_data_o <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
         remaining  <= '0;
         tcnt       <= '0;
         region_sel <= '0;
      end else begin
         state <= state_n;
         busy  <= (state_n == S_FETCH) || (state_n == S_WRITE) || (state_n == S_DONE);
         done  <= (state == S_IDLE && handshake && !hdr_bad && hdr_empty) ||
                  (state_n == S_DONE);
         case (state)
            S_IDLE: begin
               if (handshake) begin
                  if (hdr_bad) begin
                     err      <= 1'b1;
                     err_code <= 2'd1;
                  end else if (!hdr_empty) begin
                     wbm_addr_o <= BASE_ADDR + (hdr_region << REGION_SHIFT);
                     remaining  <= hdr_count;
                     region_sel <= NUM_CONFIG_REGIONS'(1) << s_data[31:24];
                  end
               end
            end
            S_FETCH: begin
               if (handshake) begin
                  wbm_data_o <= s_data;
                  wbm_cyc_o  <= 1'b1;
                  wbm_stb_o  <= 1'b1;
                  wbm_we_o   <= 1'b1;
                  tcnt       <= '0;
               end
            end
            S_WRITE: begin
               if (ack_hit) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  remaining <= remaining - CNT_W'(1);
               end else if (timed_out) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  err       <= 1'b1;
                  err_code  <= 2'd2;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            S_ERR: begin
               if (clr_err) begin
                  err      <= 1'b0;
                  err_code <= 2'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_config_loader.sv
// Self-checking bench for wb_config_loader: transfer-level model plus a
// per-cycle bus checker, driven by directed header/data vectors.
module tb_wb_config_loader;

   localparam int          TIMEOUT = 16;
   localparam logic [31:0] BASE    = 32'h3000_0000;

   localparam int SLV_NORMAL = 0;
   localparam int SLV_NEVER  = 1;
   localparam int SLV_AT16   = 2;
   localparam int SLV_WRONG0 = 3;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        clr_err = 1'b0;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] addr, wdata;
   logic [1:0]  ack = 2'b00;
   logic        busy, done, err;
   logic [1:0]  err_code;

   int n_compared = 0;
   int n_failed   = 0;

   // transfer-level model state
   wr_t         exp_q[$];
   wr_t         log_q[$];
   logic        m_in_xfer = 1'b0;
   int          m_region  = 0;
   int          m_left    = 0;
   logic [31:0] m_addr    = '0;
   logic        m_err     = 1'b0;
   logic [1:0]  m_code    = 2'd0;
   logic        m_done_hdr = 1'b0;

   // checker state
   logic        done_due = 1'b0;
   logic        drop_due = 1'b0;
   logic        prev_stb = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_data = '0;
   int          run = 0;
   int          last_run = 0;

   int slave_mode = SLV_NORMAL;
   int scnt = 0;

   always #5 clk = ~clk;

   wb_config_loader #(
      .NUM_CONFIG_REGIONS(2),
      .BASE_ADDR(BASE),
      .REGION_SHIFT(24),
      .TIMEOUT(TIMEOUT),
      .CNT_W(16)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .clr_err(clr_err),
      .wbm_cyc_o(cyc),
      .wbm_stb_o(stb),
      .wbm_we_o(we),
      .wbm_sel_o(sel),
      .wbm_addr_o(addr),
      .wbm_data_o(wdata),
      .wbm_ack_i(ack),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_failed++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkFlag(input string name, input logic act, input logic req);
      checkOutput(name, {31'b0, act}, {31'b0, req});
   endtask

   // Slave: decodes the region from the address and answers per slave_mode.
   always @(posedge clk) begin
      #1;
      if (stb) scnt++;
      else scnt = 0;
      case (slave_mode)
         SLV_NORMAL: ack = (stb && scnt >= 2) ? (2'b01 << (addr[31:24] - 8'h30)) : 2'b00;
         SLV_AT16:   ack = (stb && scnt == 16) ? (2'b01 << (addr[31:24] - 8'h30)) : 2'b00;
         SLV_WRONG0: ack = (stb && scnt[0]) ? 2'b01 : 2'b00;
         default:    ack = 2'b00;
      endcase
   end

   // Model update when a stream word is accepted.
   task automatic modelAccept(input logic [31:0] w);
      int rg;
      int cnt;
      wr_t e;
      if (!m_in_xfer) begin
         rg  = int'(w[31:24]);
         cnt = int'(w[15:0]);
         if (rg >= 2) begin
            m_err  = 1'b1;
            m_code = 2'd1;
         end else if (cnt == 0) begin
            m_done_hdr = 1'b1;
         end else begin
            m_region  = rg;
            m_addr    = BASE + (32'(rg) << 24);
            m_left    = cnt;
            m_in_xfer = 1'b1;
         end
      end else begin
         e.addr = m_addr;
         e.data = w;
         e.last = (m_left == 1);
         exp_q.push_back(e);
         m_left--;
         if (m_left == 0) m_in_xfer = 1'b0;
      end
   endtask

   task automatic modelClear();
      exp_q.delete();
      m_in_xfer  = 1'b0;
      m_left     = 0;
      m_err      = 1'b0;
      m_code     = 2'd0;
      m_done_hdr = 1'b0;
   endtask

   // Per-cycle checker: bus rules, write scoreboard, done/err timing, timeout.
   always @(negedge clk) begin
      if (rst) begin
         run      = 0;
         drop_due = 1'b0;
         done_due = 1'b0;
         prev_stb = 1'b0;
      end else begin
         checkFlag("done", done, m_done_hdr || done_due);
         m_done_hdr = 1'b0;
         done_due   = 1'b0;
         checkFlag("err", err, m_err);
         checkOutput("err_code", {30'b0, err_code}, {30'b0, m_code});
         if (drop_due) checkFlag("cyc_drop", cyc, 1'b0);
         drop_due = 1'b0;
         if (cyc) begin
            checkFlag("we_with_cyc", we, 1'b1);
            checkFlag("stb_with_cyc", stb, 1'b1);
            checkOutput("sel", {28'b0, sel}, 32'hF);
            checkFlag("ready_in_write", s_ready, 1'b0);
            checkFlag("busy_in_write", busy, 1'b1);
         end else begin
            checkFlag("stb_without_cyc", stb, 1'b0);
         end
         if (err) begin
            checkFlag("ready_in_err", s_ready, 1'b0);
            checkFlag("busy_in_err", busy, 1'b0);
         end
         if (stb && prev_stb) begin
            checkOutput("addr_stable", addr, prev_addr);
            checkOutput("data_stable", wdata, prev_data);
         end
         if (stb) begin
            run++;
            if (ack[m_region]) begin
               wr_t e;
               wr_t g;
               g.addr = addr;
               g.data = wdata;
               g.last = 1'b0;
               log_q.push_back(g);
               if (exp_q.size() == 0) begin
                  checkFlag("unexpected_write", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("wr_addr", addr, e.addr);
                  checkOutput("wr_data", wdata, e.data);
                  done_due = e.last;
               end
               last_run = run;
               run      = 0;
               drop_due = 1'b1;
            end else if (run == TIMEOUT) begin
               m_err    = 1'b1;
               m_code   = 2'd2;
               last_run = run;
               run      = 0;
               drop_due = 1'b1;
            end
         end
         prev_stb  = stb;
         prev_addr = addr;
         prev_data = wdata;
      end
   end

   task automatic applyStimulus(input logic [31:0] w);
      int n = 0;
      s_valid = 1'b1;
      s_data  = w;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checkFlag("send_timeout", 1'b0, 1'b1);
         s_valid = 1'b0;
      end else begin
         @(posedge clk);
         modelAccept(w);
         @(negedge clk);
         s_valid = 1'b0;
      end
   endtask

   task automatic clearErr();
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk);
      modelClear();
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic waitErr(input string name);
      int n = 0;
      while (!err && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkFlag(name, err, 1'b1);
   endtask

   task automatic waitDone(input string name);
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkFlag(name, done, 1'b1);
   endtask

   initial begin
      int base;

      repeat (2) @(negedge clk);
      checkFlag("rst_cyc", cyc, 1'b0);
      checkFlag("rst_stb", stb, 1'b0);
      checkFlag("rst_we", we, 1'b0);
      checkOutput("rst_addr", addr, 32'h0);
      checkOutput("rst_data", wdata, 32'h0);
      checkFlag("rst_busy", busy, 1'b0);
      checkFlag("rst_done", done, 1'b0);
      checkFlag("rst_err", err, 1'b0);
      checkOutput("rst_err_code", {30'b0, err_code}, 32'h0);
      checkFlag("rst_ready", s_ready, 1'b1);
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);

      // two writes to region 1
      base = log_q.size();
      applyStimulus(32'h0100_0002);
      checkFlag("busy_fetch", busy, 1'b1);
      applyStimulus(32'hDEAD_BEEF);
      applyStimulus(32'h1234_5678);
      waitDone("t1_done");
      checkOutput("t1_writes", log_q.size() - base, 32'd2);
      checkOutput("t1_addr0", log_q[base].addr, 32'h3100_0000);
      checkOutput("t1_data0", log_q[base].data, 32'hDEAD_BEEF);
      checkOutput("t1_data1", log_q[base+1].data, 32'h1234_5678);
      checkOutput("t1_run", last_run, 32'd2);
      @(negedge clk);

      // zero-count header
      applyStimulus(32'h0000_0000);
      checkFlag("t2_done", done, 1'b1);
      checkFlag("t2_ready", s_ready, 1'b1);
      checkFlag("t2_cyc", cyc, 1'b0);
      @(negedge clk);
      checkFlag("t2_done_once", done, 1'b0);

      // bad region
      applyStimulus(32'h0500_0003);
      checkOutput("t3_code", {30'b0, err_code}, 32'd1);
      checkFlag("t3_ready", s_ready, 1'b0);
      repeat (3) @(negedge clk);
      checkFlag("t3_err_sticky", err, 1'b1);
      clearErr();
      checkFlag("t3_err_clr", err, 1'b0);
      checkFlag("t3_ready_clr", s_ready, 1'b1);

      // slave never acks
      slave_mode = SLV_NEVER;
      applyStimulus(32'h0000_0001);
      applyStimulus(32'hCAFE_0001);
      waitErr("t4_err");
      checkOutput("t4_code", {30'b0, err_code}, 32'd2);
      checkOutput("t4_run", last_run, 32'd16);
      checkFlag("t4_cyc", cyc, 1'b0);
      clearErr();

      // ack lands on the final allowed cycle
      slave_mode = SLV_AT16;
      base = log_q.size();
      applyStimulus(32'h0000_0001);
      applyStimulus(32'hCAFE_0002);
      waitDone("t4b_done");
      checkFlag("t4b_err", err, 1'b0);
      checkOutput("t4b_run", last_run, 32'd16);
      checkOutput("t4b_data", log_q[base].data, 32'hCAFE_0002);
      checkOutput("t4b_addr", log_q[base].addr, 32'h3000_0000);
      checkOutput("t4b_q_empty", exp_q.size(), 32'd0);
      @(negedge clk);

      // ack on the wrong region bit
      slave_mode = SLV_WRONG0;
      base = log_q.size();
      applyStimulus(32'h0100_0001);
      applyStimulus(32'h0BAD_0001);
      waitErr("t5_err");
      checkOutput("t5_code", {30'b0, err_code}, 32'd2);
      checkOutput("t5_no_write", log_q.size() - base, 32'd0);
      clearErr();

      // bubbles, then reset mid-write
      slave_mode = SLV_NORMAL;
      applyStimulus(32'h0000_0002);
      applyStimulus(32'h5555_0001);
      repeat (5) @(negedge clk);
      checkFlag("t6_bubble_cyc", cyc, 1'b0);
      checkFlag("t6_bubble_busy", busy, 1'b1);
      checkFlag("t6_bubble_ready", s_ready, 1'b1);
      applyStimulus(32'h5555_0002);
      checkFlag("t6_stb_up", stb, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      modelClear();
      checkFlag("t6_rst_cyc", cyc, 1'b0);
      checkFlag("t6_rst_stb", stb, 1'b0);
      checkOutput("t6_rst_addr", addr, 32'h0);
      checkOutput("t6_rst_data", wdata, 32'h0);
      checkFlag("t6_rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      checkFlag("t6_idle_ready", s_ready, 1'b1);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
